// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Shared VGA timing constants for the sync generator and the downstream
//   pixel generators: the default 640x480@60 geometry, the coordinate width,
//   and helpers that derive the line/frame totals from the porch and sync
//   widths.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  // Width of pixel_x / pixel_y everywhere in the video pipeline.
  localparam int COORD_W   = 10;
  localparam int MAX_TOTAL = 1 << COORD_W;

  // Default 640x480@60 geometry (25 MHz pixel clock from a 50 MHz board clock).
  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  // Pixels per line, including blanking.
  function automatic int h_total(input int disp, input int front,
                                 input int sync, input int back);
    return disp + front + sync + back;
  endfunction

  // Lines per frame, including blanking.
  function automatic int v_total(input int disp, input int front,
                                 input int sync, input int back);
    return disp + front + sync + back;
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// ---------------------------------------------------------------------------
// pixel_tick_div
//   Divides the system clock down to a one-clock pixel enable.
//   Ports:
//     clk     in   system clock
//     reset   in   asynchronous, active-high reset
//     p_tick  out  high for one clk every CLK_DIV clks (held high if CLK_DIV=1)
// ---------------------------------------------------------------------------
module pixel_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("pixel_tick_div: CLK_DIV must be in 1..16");
  end

  // A one-bit counter is kept for CLK_DIV=1 so the register never has zero width.
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] div_d;

  always_comb div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

  // Straight compare of a register: no combinational input path, so no glitches.
  assign p_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//   Free-running VGA timing generator: pixel enable, horizontal/vertical
//   counters and registered sync/blanking decodes.
//   Ports:
//     clk          in   system clock
//     reset        in   asynchronous, active-high reset
//     p_tick       out  pixel enable, one clk every CLK_DIV clks
//     pixel_x      out  current column, 0..H_TOTAL-1
//     pixel_y      out  current line, 0..V_TOTAL-1
//     video_on     out  1 inside the visible H_DISPLAY x V_DISPLAY area
//     hsync        out  active-low horizontal sync
//     vsync        out  active-low vertical sync
//     frame_start  out  one-clk pulse when the counters wrap to (0,0)
// ---------------------------------------------------------------------------
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic               clk,
  input  logic               reset,
  output logic               p_tick,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start
);

  localparam int H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_totals
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed %0d", MAX_TOTAL);
  end

  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic               hsync_q, vsync_q, video_on_q, frame_start_q;
  logic               frame_wrap, hs_active, vs_active, visible;

  pixel_tick_div #(.CLK_DIV(CLK_DIV)) u_tick_div (
    .clk    (clk),
    .reset  (reset),
    .p_tick (p_tick)
  );

  // Counters only move on pixel-enable clocks; y steps when x wraps.
  always_comb begin
    // NOTE: hold values assigned first so every path drives x_d/y_d and no latch is inferred.
    x_d = x_q;
    y_d = y_q;
    if (p_tick) begin
      if (x_q != H_LAST) begin
        x_d = x_q + 1'b1;
      end else begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
      end
    end
  end

  assign frame_wrap = p_tick && (x_q == H_LAST) && (y_q == V_LAST);

  // Decoded from the next-state counters so the registered outputs change on
  // the same edge as pixel_x/pixel_y rather than one clock later.
  assign hs_active = (x_d >= HS_FIRST) && (x_d <= HS_LAST);
  assign vs_active = (y_d >= VS_FIRST) && (y_d <= VS_LAST);
  assign visible   = (x_d < H_VIS) && (y_d < V_VIS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= ~hs_active;
      vsync_q       <= ~vs_active;
      video_on_q    <= visible;
      frame_start_q <= frame_wrap;
    end
  end

  assign pixel_x     = x_q;
  assign pixel_y     = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

endmodule
